// File: rtl/mio_bus_responder_pkg.sv
// Shared address map, FSM encodings and decode helper for the MEM-stage
// memory/IO responder.
package mio_bus_responder_pkg;

  localparam logic [31:0] MIO_LED_ADDR = 32'hF000_0000;
  localparam logic [31:0] MIO_SW_ADDR  = 32'hF000_0004;
  localparam logic [31:0] MIO_TMR_ADDR = 32'hF000_0008;
  localparam logic [3:0]  MIO_IO_PAGE  = 4'hF;

  // Wide enough for RAM_LAT-1 with RAM_LAT up to 7.
  localparam int MIO_WAIT_W = 3;

  typedef enum logic [1:0] {
    MIO_IDLE  = 2'd0,
    MIO_RWAIT = 2'd1,
    MIO_DONE  = 2'd2
  } mio_state_e;

  typedef enum logic [2:0] {
    MIO_SEL_RAM  = 3'd0,
    MIO_SEL_LED  = 3'd1,
    MIO_SEL_SW   = 3'd2,
    MIO_SEL_TMR  = 3'd3,
    MIO_SEL_NONE = 3'd4
  } mio_sel_e;

  // Word-granular decode: byte-offset bits [1:0] never take part.
  function automatic mio_sel_e mio_decode(input logic [31:0] addr);
    mio_sel_e sel;
    if (addr[31:28] != MIO_IO_PAGE) begin
      sel = MIO_SEL_RAM;
    end else if (addr[31:2] == MIO_LED_ADDR[31:2]) begin
      sel = MIO_SEL_LED;
    end else if (addr[31:2] == MIO_SW_ADDR[31:2]) begin
      sel = MIO_SEL_SW;
    end else if (addr[31:2] == MIO_TMR_ADDR[31:2]) begin
      sel = MIO_SEL_TMR;
    end else begin
      sel = MIO_SEL_NONE;
    end
    return sel;
  endfunction

endpackage

// File: rtl/mio_timer.sv
// Free-running 32-bit timer; a CPU write overrides the increment for that cycle.
module mio_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] count
);

  logic [31:0] count_q;
  logic [31:0] count_d;

  always_comb begin
    count_d = count_q + 32'd1;
    if (we) begin
      count_d = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/mio_bus_responder.sv
// MEM-stage responder: decodes word accesses to RAM/LED/switch/timer and drives
// MIO_ready as the pipeline stall input, holding it low across RAM wait states.
module mio_bus_responder
  import mio_bus_responder_pkg::*;
#(
  parameter int RAM_AW  = 10,
  parameter int RAM_LAT = 2,
  parameter int SW_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              MIO_ready,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_we,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       led_out,
  input  logic [SW_W-1:0]   sw_in
);

  localparam logic [MIO_WAIT_W-1:0] WAIT_INIT = MIO_WAIT_W'(RAM_LAT - 1);

  mio_state_e             state_q, state_d;
  logic [MIO_WAIT_W-1:0]  wait_q, wait_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [31:0]            led_q, led_d;
  logic [SW_W-1:0]        sw_meta_q, sw_sync_q;

  mio_sel_e               sel;
  logic                   io_start;
  logic                   tmr_we;
  logic [31:0]            tmr_count;
  logic [31:0]            io_rdata;
  logic                   unused_addr_lsb;

  assign unused_addr_lsb = ^cpu_addr[1:0];

  assign sel      = mio_decode(cpu_addr);
  assign io_start = (state_q == MIO_IDLE) && cpu_req && (sel != MIO_SEL_RAM);
  assign tmr_we   = io_start && cpu_we && (sel == MIO_SEL_TMR);

  mio_timer u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (tmr_we),
    .wdata (cpu_wdata),
    .count (tmr_count)
  );

  // Peripheral read mux; the timer contributes its value before this edge.
  always_comb begin
    io_rdata = '0;
    case (sel)
      MIO_SEL_LED: io_rdata = led_q;
      MIO_SEL_SW:  io_rdata = 32'(sw_sync_q);
      MIO_SEL_TMR: io_rdata = tmr_count;
      default:     io_rdata = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    rdata_d   = rdata_q;
    led_d     = led_q;
    ram_we    = 1'b0;
    MIO_ready = 1'b0;
    case (state_q)
      MIO_IDLE: begin
        if (!cpu_req) begin
          MIO_ready = 1'b1;
        end else if (sel == MIO_SEL_RAM) begin
          if (cpu_we) begin
            ram_we  = 1'b1;
            state_d = MIO_DONE;
          end else begin
            wait_d  = WAIT_INIT;
            state_d = MIO_RWAIT;
          end
        end else begin
          if (cpu_we) begin
            if (sel == MIO_SEL_LED) begin
              led_d = cpu_wdata;
            end
          end else begin
            rdata_d = io_rdata;
          end
          state_d = MIO_DONE;
        end
      end
      // A dropped cpu_req here is a flush; the read still runs to completion.
      MIO_RWAIT: begin
        if (wait_q == '0) begin
          rdata_d = ram_rdata;
          state_d = MIO_DONE;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      MIO_DONE: begin
        MIO_ready = 1'b1;
        state_d   = MIO_IDLE;
      end
      default: begin
        state_d = MIO_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MIO_IDLE;
      wait_q    <= '0;
      rdata_q   <= '0;
      led_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      rdata_q   <= rdata_d;
      led_q     <= led_d;
      sw_meta_q <= sw_in;
      sw_sync_q <= sw_meta_q;
    end
  end

  assign cpu_rdata = rdata_q;
  assign ram_addr  = cpu_addr[RAM_AW+1:2];
  assign ram_wdata = cpu_wdata;
  assign led_out   = led_q;

endmodule

// File: tb/tb_mio_bus_responder.sv
// Randomised self-checking bench for mio_bus_responder against a transaction-level model.
module tb_mio_bus_responder;
  import mio_bus_responder_pkg::*;

  localparam int RAM_AW  = 10;
  localparam int RAM_LAT = 2;
  localparam int SW_W    = 16;
  localparam int MAX_LAT = 20;

  logic              clk;
  logic              rst_n;
  logic              cpu_req;
  logic              cpu_we;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              MIO_ready;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic              ram_we;
  logic [31:0]       ram_rdata;
  logic [31:0]       led_out;
  logic [SW_W-1:0]   sw_in;

  mio_bus_responder #(
    .RAM_AW  (RAM_AW),
    .RAM_LAT (RAM_LAT),
    .SW_W    (SW_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .MIO_ready (MIO_ready),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata),
    .led_out   (led_out),
    .sw_in     (sw_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bench-side RAM with a fixed read pipeline of RAM_LAT stages.
  logic [31:0] mem   [1 << RAM_AW];
  logic [31:0] rpipe [RAM_LAT];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    rpipe[0] <= mem[ram_addr];
    for (int i = 1; i < RAM_LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign ram_rdata = rpipe[RAM_LAT-1];

  // Reference model state.
  logic [31:0]     exp_mem [1 << RAM_AW];
  logic [31:0]     exp_led;
  logic [SW_W-1:0] sw_cur;
  logic [31:0]     tmr_base_val;
  int              tmr_base_cyc;

  int n_checks = 0;
  int n_errors = 0;
  int n_txn    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] tmr_at(input int c);
    return tmr_base_val + 32'(c - tmr_base_cyc);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input int c);
    if (a[31:28] != MIO_IO_PAGE)            return exp_mem[int'(a[RAM_AW+1:2])];
    if (a[31:2] == MIO_LED_ADDR[31:2])      return exp_led;
    if (a[31:2] == MIO_SW_ADDR[31:2])       return 32'(sw_cur);
    if (a[31:2] == MIO_TMR_ADDR[31:2])      return tmr_at(c);
    return 32'h0;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input int c);
    if (a[31:28] != MIO_IO_PAGE)            exp_mem[int'(a[RAM_AW+1:2])] = d;
    else if (a[31:2] == MIO_LED_ADDR[31:2]) exp_led = d;
    else if (a[31:2] == MIO_TMR_ADDR[31:2]) begin
      tmr_base_cyc = c + 1;
      tmr_base_val = d;
    end
  endtask

  task automatic model_reset();
    exp_led      = 32'h0;
    tmr_base_val = 32'h0;
    tmr_base_cyc = cyc;
  endtask

  // Issue one request at the current negedge and follow it to its MIO_ready pulse.
  task automatic do_access(input logic we, input logic [31:0] a, input logic [31:0] d);
    int          s, k, nwe, exp_lat;
    logic        is_ram;
    logic [31:0] exp_rd;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = d;
    s       = cyc;
    is_ram  = (a[31:28] != MIO_IO_PAGE);
    exp_lat = (is_ram && !we) ? RAM_LAT + 1 : 1;
    exp_rd  = model_read(a, s);
    k = 0;
    nwe = 0;
    #1;
    while (MIO_ready !== 1'b1 && k < MAX_LAT) begin
      if (ram_we === 1'b1) begin
        nwe++;
        chk("ram_addr", 32'(ram_addr), 32'(a[RAM_AW+1:2]));
        chk("ram_wdata", ram_wdata, d);
      end
      @(negedge clk);
      k++;
      #1;
    end
    if (ram_we === 1'b1) nwe++;
    chk("latency", k, exp_lat);
    chk("ram_we_count", nwe, (is_ram && we) ? 1 : 0);
    if (!we) chk("rdata", cpu_rdata, exp_rd);
    if (we) model_write(a, d, s);
    chk("led_out", led_out, exp_led);
    n_txn++;
    $display("txn %0d cyc=%0d %s addr=%h wdata=%h rdata=%h lat=%0d",
             n_txn, s, we ? "sw" : "lw", a, d, cpu_rdata, k);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cpu_req = 1'b0;
      cpu_we  = 1'($urandom);
      #1;
      chk("idle_ready", 32'(MIO_ready), 32'd1);
      chk("idle_ram_we", 32'(ram_we), 32'd0);
    end
  endtask

  function automatic logic [31:0] rand_addr(input int kind);
    logic [31:0] a;
    a = $urandom;
    case (kind)
      0: begin
        a[31:28] = 4'($urandom_range(0, 14));
        a[RAM_AW+1:2] = RAM_AW'($urandom_range(0, 15));
      end
      1: a[31:2] = MIO_LED_ADDR[31:2];
      2: a[31:2] = MIO_SW_ADDR[31:2];
      3: a[31:2] = MIO_TMR_ADDR[31:2];
      default: begin
        a[31:28] = MIO_IO_PAGE;
        if (a[31:4] == MIO_LED_ADDR[31:4]) a = 32'hF000_0100;
      end
    endcase
    return a;
  endfunction

  initial begin
    int s0;
    rst_n     = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
    sw_in     = 16'h1234;
    sw_cur    = 16'h1234;
    for (int i = 0; i < (1 << RAM_AW); i++) exp_mem[i] = 32'h0;

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 32'(MIO_ready), 32'd1);
    chk("rst_led", led_out, 32'h0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Directed: store, load, LED, switch, timer wrap.
    @(negedge clk); do_access(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    idle(1);
    @(negedge clk); do_access(1'b0, 32'h0000_0010, 32'h0);
    @(negedge clk); do_access(1'b1, MIO_LED_ADDR, 32'h0000_005A);
    @(negedge clk); do_access(1'b0, MIO_SW_ADDR, 32'h0);
    @(negedge clk); do_access(1'b1, MIO_SW_ADDR, 32'hFFFF_FFFF);
    @(negedge clk); do_access(1'b1, MIO_TMR_ADDR, 32'hFFFF_FFFE);
    @(negedge clk); do_access(1'b0, MIO_TMR_ADDR, 32'h0);
    @(negedge clk); do_access(1'b0, MIO_TMR_ADDR, 32'h0);

    // Back-to-back with cpu_req held high throughout.
    idle(1);
    s0 = cyc + 1;
    @(negedge clk); do_access(1'b0, 32'h0000_0010, 32'h0);
    @(negedge clk); do_access(1'b1, 32'h0000_0014, $urandom);
    @(negedge clk); do_access(1'b0, 32'hF000_0100, 32'h0);
    chk("b2b_cycles", cyc - s0 + 1, (RAM_LAT + 2) + 2 + 2);

    // Flush: request withdrawn mid-read must not abort the access.
    idle(1);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0010;
    #1 chk("flush_start", 32'(MIO_ready), 32'd0);
    @(negedge clk);
    cpu_req = 1'b0;
    #1 chk("flush_wait", 32'(MIO_ready), 32'd0);
    for (int i = 2; i <= RAM_LAT; i++) begin
      @(negedge clk);
      #1 chk("flush_wait", 32'(MIO_ready), 32'd0);
    end
    @(negedge clk);
    #1 chk("flush_done", 32'(MIO_ready), 32'd1);
    chk("flush_rdata", cpu_rdata, exp_mem[4]);

    // Asynchronous reset in the middle of a RAM read.
    idle(1);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0010;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready_req", 32'(MIO_ready), 32'd0);
    chk("midrst_rdata", cpu_rdata, 32'h0);
    chk("midrst_led", led_out, 32'h0);
    chk("midrst_ram_we", 32'(ram_we), 32'd0);
    cpu_req = 1'b0;
    #1 chk("midrst_ready_idle", 32'(MIO_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1 chk("post_rst_ready", 32'(MIO_ready), 32'd1);
    chk("post_rst_rdata", cpu_rdata, 32'h0);
    @(negedge clk); do_access(1'b0, 32'h0000_0010, 32'h0);

    // Prefill the random working set so every RAM load has defined data.
    for (int w = 0; w < 16; w++) begin
      @(negedge clk); do_access(1'b1, 32'(w) << 2, $urandom);
    end

    // Randomised mix of accesses with random idle gaps.
    for (int t = 0; t < 300; t++) begin
      int kind;
      kind = $urandom_range(0, 5);
      if (kind == 5) kind = 0;
      @(negedge clk);
      do_access(1'($urandom), rand_addr(kind), $urandom);
      idle($urandom_range(0, 2));
      if ($urandom_range(0, 15) == 0) begin
        @(negedge clk);
        cpu_req = 1'b0;
        sw_in   = SW_W'($urandom);
        sw_cur  = sw_in;
        idle(3);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
